// File: rtl/phys_reg_file_if.sv
// Bundles the read, write and dump signals of the physical register file.
// The master drives indices, write data and dump handshake inputs; the slave is the register file.
interface phys_reg_file_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] rd1_addr;
  logic [ADDR_W-1:0] rd2_addr;
  logic [ADDR_W-1:0] rd0_addr;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic [DATA_W-1:0] rd0_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              dump_req;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              busy;

  modport master (
    output rd1_addr, rd2_addr, rd0_addr,
    output wr_en, wr_addr, wr_data,
    output dump_req, dump_ready,
    input  rd1_data, rd2_data, rd0_data,
    input  dump_valid, dump_addr, dump_data, busy
  );

  modport slave (
    input  rd1_addr, rd2_addr, rd0_addr,
    input  wr_en, wr_addr, wr_data,
    input  dump_req, dump_ready,
    output rd1_data, rd2_data, rd0_data,
    output dump_valid, dump_addr, dump_data, busy
  );
endinterface

// File: rtl/phys_reg_file.sv
// Physical register file behind the register mapper: one-entry write-back buffer with full
// read bypass, plus a handshaked engine that streams every register out for debug.
module phys_reg_file #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  parameter int ADDR_W = $clog2(NREG)
) (
  input logic             clk,
  input logic             reset,
  phys_reg_file_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DUMP = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  logic [DATA_W-1:0] regs [NREG];
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [0:0]        state;
  logic [ADDR_W-1:0] dump_idx;

  // A pending buffer entry commits while a new write may load in the same edge, so writes never stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      if (wb_valid) begin
        regs[wb_addr] <= wb_data;
      end
      wb_valid <= bus.wr_en;
      if (bus.wr_en) begin
        wb_addr <= bus.wr_addr;
        wb_data <= bus.wr_data;
      end
    end
  end

  assign bus.rd1_data  = (wb_valid && wb_addr == bus.rd1_addr) ? wb_data : regs[bus.rd1_addr];
  assign bus.rd2_data  = (wb_valid && wb_addr == bus.rd2_addr) ? wb_data : regs[bus.rd2_addr];
  assign bus.rd0_data  = (wb_valid && wb_addr == bus.rd0_addr) ? wb_data : regs[bus.rd0_addr];
  assign bus.dump_data = (wb_valid && wb_addr == dump_idx)     ? wb_data : regs[dump_idx];

  // Dump requests arriving mid-dump are dropped; the last accepted beat returns the engine to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dump_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dump_req) begin
            state    <= DUMP;
            dump_idx <= '0;
          end
        end
        DUMP: begin
          if (bus.dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state    <= IDLE;
              dump_idx <= '0;
            end else begin
              dump_idx <= dump_idx + ADDR_W'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          dump_idx <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = (state == DUMP);
  assign bus.dump_valid = (state == DUMP);
  assign bus.dump_addr  = dump_idx;

endmodule

// File: tb/tb_phys_reg_file.sv
// Directed checks of the register file: bypass timing, back-to-back writes, dump handshake and reset abort.
module tb_phys_reg_file;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  phys_reg_file_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  phys_reg_file #(.DATA_W(8), .NREG(4), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [1:0] idx, input logic [7:0] value);
    check_output({tag, " valid"}, 32'(bus.dump_valid), 32'd1);
    check_output({tag, " busy"},  32'(bus.busy),       32'd1);
    check_output({tag, " addr"},  32'(bus.dump_addr),  32'(idx));
    check_output({tag, " data"},  32'(bus.dump_data),  32'(value));
  endtask

  task automatic start_dump();
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
  endtask

  logic [7:0] exp_dump [4];
  logic [7:0] preload  [4];

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.rd1_addr = '0;
    bus.rd2_addr = '0;
    bus.rd0_addr = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.dump_req   = 1'b0;
    bus.dump_ready = 1'b0;
    tick();
    tick();
    check_output("reset rd1", 32'(bus.rd1_data), 32'h0);
    check_output("reset dump_valid", 32'(bus.dump_valid), 32'h0);
    check_output("reset busy", 32'(bus.busy), 32'h0);
    check_output("reset dump_addr", 32'(bus.dump_addr), 32'h0);
    reset = 1'b0;
    tick();

    // Write A5 to idx 2: invisible same cycle, bypassed next cycle, from the array later.
    bus.rd1_addr = 2'd2;
    bus.rd2_addr = 2'd2;
    bus.rd0_addr = 2'd2;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 2'd2;
    bus.wr_data  = 8'hA5;
    #1;
    check_output("same-cycle no bypass", 32'(bus.rd1_data), 32'h0);
    tick();
    bus.wr_en = 1'b0;
    check_output("wb bypass rd1", 32'(bus.rd1_data), 32'hA5);
    check_output("wb bypass rd2", 32'(bus.rd2_data), 32'hA5);
    check_output("wb bypass rd0", 32'(bus.rd0_data), 32'hA5);
    tick();
    tick();
    check_output("array rd1", 32'(bus.rd1_data), 32'hA5);

    // Back-to-back writes to idx 1.
    bus.rd1_addr = 2'd1;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 2'd1;
    bus.wr_data  = 8'h11;
    tick();
    bus.wr_data  = 8'h22;
    check_output("b2b first", 32'(bus.rd1_data), 32'h11);
    tick();
    bus.wr_en = 1'b0;
    check_output("b2b second", 32'(bus.rd1_data), 32'h22);
    tick();
    check_output("b2b array", 32'(bus.rd1_data), 32'h22);

    exp_dump[0] = 8'h00;
    exp_dump[1] = 8'h22;
    exp_dump[2] = 8'hA5;
    exp_dump[3] = 8'h00;
    bus.dump_ready = 1'b1;
    start_dump();
    for (int i = 0; i < 4; i++) begin
      check_beat($sformatf("dumpA beat%0d", i), 2'(i), exp_dump[i]);
      tick();
    end
    check_output("dumpA done busy", 32'(bus.busy), 32'h0);

    // Preload all four registers, then dump with a 3-cycle stall on beat 1.
    preload[0] = 8'h10;
    preload[1] = 8'h20;
    preload[2] = 8'h30;
    preload[3] = 8'h40;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_data = preload[i];
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
    start_dump();
    check_beat("dumpB beat0", 2'd0, 8'h10);
    tick();
    bus.dump_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_beat($sformatf("dumpB stall%0d", s), 2'd1, 8'h20);
      tick();
    end
    check_beat("dumpB beat1", 2'd1, 8'h20);
    bus.dump_ready = 1'b1;
    tick();
    check_beat("dumpB beat2", 2'd2, 8'h30);
    tick();
    check_beat("dumpB beat3", 2'd3, 8'h40);
    tick();
    check_output("dumpB done busy", 32'(bus.busy), 32'h0);
    check_output("dumpB done valid", 32'(bus.dump_valid), 32'h0);

    // Stall at idx 3 and write FF there; the held beat must follow the write.
    start_dump();
    tick();
    tick();
    tick();
    bus.dump_ready = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = 8'hFF;
    check_beat("dumpC stall old", 2'd3, 8'h40);
    tick();
    bus.wr_en = 1'b0;
    check_beat("dumpC stall new", 2'd3, 8'hFF);
    tick();
    check_beat("dumpC accepted", 2'd3, 8'hFF);
    bus.dump_ready = 1'b1;
    tick();
    check_output("dumpC done busy", 32'(bus.busy), 32'h0);

    // Reset in the middle of a dump at idx 2 aborts it and clears the file.
    bus.rd1_addr = 2'd3;
    bus.rd2_addr = 2'd1;
    bus.rd0_addr = 2'd2;
    start_dump();
    tick();
    tick();
    check_beat("dumpD pre-reset", 2'd2, 8'h30);
    #3;
    reset = 1'b1;
    #1;
    check_output("midreset busy", 32'(bus.busy), 32'h0);
    check_output("midreset valid", 32'(bus.dump_valid), 32'h0);
    check_output("midreset rd1", 32'(bus.rd1_data), 32'h0);
    check_output("midreset rd2", 32'(bus.rd2_data), 32'h0);
    check_output("midreset rd0", 32'(bus.rd0_data), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    start_dump();
    for (int i = 0; i < 4; i++) begin
      check_beat($sformatf("dumpE beat%0d", i), 2'(i), 8'h00);
      tick();
    end
    check_output("dumpE done busy", 32'(bus.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
